// File: rtl/lift_pkg.sv
// lift_pkg: shared types and default constants for the lift scan controller.
//   lift_state_e      : controller state encoding (IDLE / MOVE / DOOR)
//   TIME_UNIT_DEF     : default clk cycles per time unit
//   MOVE_UNITS_DEF    : default time units to travel one floor
//   DOOR_ODD_MUL_DEF  : default door-time multiplier on odd floors
//   DOOR_EVEN_MUL_DEF : default door-time multiplier on even nonzero floors
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } lift_state_e;

  localparam int TIME_UNIT_DEF     = 100_000_000;
  localparam int MOVE_UNITS_DEF    = 1;
  localparam int DOOR_ODD_MUL_DEF  = 4;
  localparam int DOOR_EVEN_MUL_DEF = 7;

endpackage

// File: rtl/lift_door_timer.sv
// lift_door_timer: works out the door-open duration for a floor and counts it.
//   clk, rst : clock, synchronous active-high reset
//   start    : load the duration for 'floor' and begin counting
//   restart  : reload the duration (door re-requested at this floor)
//   hold     : keep the elapsed time at zero while high
//   floor    : floor whose duration is loaded on start/restart/hold
//   done     : one-cycle pulse in the last cycle of the door period
// Duration in time units: floor 0 -> 1, odd -> ODD_MUL*floor,
// even nonzero -> EVEN_MUL*floor.
module lift_door_timer
  import lift_pkg::*;
#(
  parameter int N_FLOORS  = 16,
  parameter int TIME_UNIT = TIME_UNIT_DEF,
  parameter int ODD_MUL   = DOOR_ODD_MUL_DEF,
  parameter int EVEN_MUL  = DOOR_EVEN_MUL_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        restart,
  input  logic                        hold,
  input  logic [$clog2(N_FLOORS)-1:0] floor,
  output logic                        done
);

  localparam int     MAX_MUL = (ODD_MUL > EVEN_MUL) ? ODD_MUL : EVEN_MUL;
  localparam longint MAX_DUR = longint'(MAX_MUL) * longint'(N_FLOORS - 1) * longint'(TIME_UNIT);
  // The counter holds duration-1, so MAX_DUR-1 is the largest value stored.
  localparam int     DW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  longint        units;
  logic [DW-1:0] dur_m1;
  logic [DW-1:0] cnt;
  logic          active;

  always_comb begin
    if (floor == '0) begin
      units = 1;
    end else if (floor[0]) begin
      units = longint'(ODD_MUL) * longint'(floor);
    end else begin
      units = longint'(EVEN_MUL) * longint'(floor);
    end
    dur_m1 = DW'(units * longint'(TIME_UNIT) - 1);
  end

  // Hold and restart both reload the full duration, so the door always
  // gets a complete period once they drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= dur_m1;
    end else if (active) begin
      if (restart || hold) begin
        cnt <= dur_m1;
      end else if (cnt == '0) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign done = active && !restart && !hold && (cnt == '0);

endmodule

// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: scan (elevator-algorithm) lift controller.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : call request strobe, one floor per cycle
//   req_floor  : requested floor (out-of-range values are dropped)
//   door_hold  : only with LIFT_DOOR_HOLD_EN defined; keeps the door open
//   floor      : current floor
//   dir_up     : current/last travel direction, 1 = up
//   moving     : lift is travelling
//   door_open  : door is open
//   pending    : outstanding request bitmap
//   music_en   : floor is neither the bottom nor the top floor
// Optional feature macro: LIFT_DOOR_HOLD_EN (adds door_hold).
//
// state | meaning
// IDLE  | parked; picks door, direction or stays, from pending requests
// MOVE  | travelling; one floor per MOVE_UNITS*TIME_UNIT cycles
// DOOR  | door open for the floor-dependent duration
module lift_scan_ctrl
  import lift_pkg::*;
#(
  parameter int N_FLOORS      = 16,
  parameter int TIME_UNIT     = TIME_UNIT_DEF,
  parameter int MOVE_UNITS    = MOVE_UNITS_DEF,
  parameter int DOOR_ODD_MUL  = DOOR_ODD_MUL_DEF,
  parameter int DOOR_EVEN_MUL = DOOR_EVEN_MUL_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [$clog2(N_FLOORS)-1:0] req_floor,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                        door_hold,
`endif
  output logic [$clog2(N_FLOORS)-1:0] floor,
  output logic                        dir_up,
  output logic                        moving,
  output logic                        door_open,
  output logic [N_FLOORS-1:0]         pending,
  output logic                        music_en
);

  localparam int     FW          = $clog2(N_FLOORS);
  localparam longint MOVE_CYC    = longint'(MOVE_UNITS) * longint'(TIME_UNIT);
  localparam int     MW          = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
  localparam logic [MW-1:0] MOVE_RELOAD = MW'(MOVE_CYC - 1);

  lift_state_e         state, state_nxt;
  logic [FW-1:0]       floor_nxt, step_floor;
  logic                dir_nxt;
  logic [MW-1:0]       move_cnt;
  logic                move_load;
  logic [N_FLOORS-1:0] acc_mask, clr_mask;
  logic                in_range;
  logic                door_start, door_restart, door_hold_i, door_done;
  logic                step_ahead, step_behind;

  function automatic logic any_above(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(f)) r = r | p[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i < int'(f)) r = r | p[i];
    end
    return r;
  endfunction

  // With a power-of-two floor count every encodable floor exists.
  generate
    if (N_FLOORS == (1 << FW)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (req_floor < FW'(N_FLOORS));
    end
  endgenerate

`ifdef LIFT_DOOR_HOLD_EN
  assign door_hold_i = door_hold;
`else
  assign door_hold_i = 1'b0;
`endif

  // A request for the floor whose door is open only extends the door.
  assign door_restart = (state == ST_DOOR) && req_valid && (req_floor == floor);
  assign acc_mask     = (req_valid && in_range && !door_restart) ?
                        (N_FLOORS'(1) << req_floor) : '0;
  // Clearing wins over setting, so a same-cycle request is absorbed.
  assign clr_mask     = door_start ? (N_FLOORS'(1) << floor_nxt) : '0;

  // MOVE only starts or continues with a request ahead, so this never wraps.
  assign step_floor  = dir_up ? (floor + 1'b1) : (floor - 1'b1);
  assign step_ahead  = dir_up ? any_above(pending, step_floor) : any_below(pending, step_floor);
  assign step_behind = dir_up ? any_below(pending, step_floor) : any_above(pending, step_floor);

  always_comb begin
    state_nxt  = state;
    floor_nxt  = floor;
    dir_nxt    = dir_up;
    move_load  = 1'b0;
    door_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending[floor]) begin
          state_nxt  = ST_DOOR;
          door_start = 1'b1;
        end else if (any_above(pending, floor) && (dir_up || !any_below(pending, floor))) begin
          state_nxt = ST_MOVE;
          dir_nxt   = 1'b1;
          move_load = 1'b1;
        end else if (any_below(pending, floor)) begin
          state_nxt = ST_MOVE;
          dir_nxt   = 1'b0;
          move_load = 1'b1;
        end
      end
      ST_MOVE: begin
        if (move_cnt == '0) begin
          floor_nxt = step_floor;
          if (pending[step_floor]) begin
            state_nxt  = ST_DOOR;
            door_start = 1'b1;
          end else if (step_ahead) begin
            move_load = 1'b1;
          end else if (step_behind) begin
            dir_nxt   = !dir_up;
            move_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (door_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      floor    <= '0;
      dir_up   <= 1'b1;
      pending  <= '0;
      move_cnt <= '0;
    end else begin
      state   <= state_nxt;
      floor   <= floor_nxt;
      dir_up  <= dir_nxt;
      pending <= (pending | acc_mask) & ~clr_mask;
      if (move_load) begin
        move_cnt <= MOVE_RELOAD;
      end else if ((state == ST_MOVE) && (move_cnt != '0)) begin
        move_cnt <= move_cnt - 1'b1;
      end
    end
  end

  // floor_nxt is the entry floor on start and the current floor in DOOR.
  lift_door_timer #(
    .N_FLOORS  (N_FLOORS),
    .TIME_UNIT (TIME_UNIT),
    .ODD_MUL   (DOOR_ODD_MUL),
    .EVEN_MUL  (DOOR_EVEN_MUL)
  ) u_door_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (door_start),
    .restart (door_restart),
    .hold    (door_hold_i),
    .floor   (floor_nxt),
    .done    (door_done)
  );

  assign moving    = (state == ST_MOVE);
  assign door_open = (state == ST_DOOR);
  assign music_en  = (floor != '0) && (floor != FW'(N_FLOORS - 1));

endmodule
